stream_mux_sliced: RTL and testbench
====================================

// Module: stream_mux_sliced
// PURPOSE
//   Registered N:1 stream multiplexer with valid/ready handshake, fixed-select
//   or round-robin channel choice; W-bit datapath built from W/SLICE_W narrow
//   slice muxes. Sits between parallel producer channels and one consumer.
// PARAMETERS
//   N_IN     4   number of input channels (>=2)
//   W        8   data width per channel
//   SLICE_W  2   width of one slice mux; W % SLICE_W == 0 (elaboration error otherwise)
//   SEL_W    $clog2(N_IN)  derived, not overridable
// PORTS
//   clk        in   1          single clock, all state on posedge
//   rst        in   1          synchronous, active-low reset
//   mode       in   1          0 = fixed select via sel, 1 = round-robin
//   sel        in   SEL_W      channel index in fixed mode; ignored in RR mode
//   in_valid   in   N_IN       per-channel valid
//   in_data    in   N_IN*W     channel i at [i*W +: W]
//   in_ready   out  N_IN       per-channel ready (combinational)
//   out_valid  out  1          output register holds a word
//   out_data   out  W          registered data
//   out_src    out  SEL_W      channel index the held word came from
//   out_ready  in   1          consumer ready
// BEHAVIOUR
//   - Reset (rst==0 at posedge): out_valid=0, out_data=0, out_src=0, rr_ptr=0.
//     Word in output register is dropped; in_ready all 0 while rst==0.
//   - load_en = !out_valid || out_ready (output register free or draining).
//   - Grant (combinational, one-hot or none):
//       fixed: grant = sel if sel < N_IN && in_valid[sel]; else none.
//       RR:    first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_IN.
//   - in_ready[i] = load_en && grant valid && grant==i; at most one bit set.
//   - Transfer on channel i when in_valid[i] && in_ready[i]: next cycle
//     out_valid=1, out_data=in_data[i], out_src=i. Latency exactly 1 cycle.
//   - If load_en && no grant: out_valid<=0 (a drained word is not repeated).
//   - If !load_en: out_* hold; data must not change while out_valid && !out_ready.
//   - Simultaneous drain+load (out_valid && out_ready && grant): new word loaded
//     same edge; full throughput 1 word/cycle, no bubble.
//   - RR pointer: on transfer in RR mode rr_ptr <= (grant+1) mod N_IN (wraps
//     N_IN-1 -> 0); unchanged in fixed mode or without transfer.
//   - mode/sel sampled combinationally each cycle; change takes effect on the
//     next transfer; held output word is unaffected.
//   - sel >= N_IN (non-power-of-2 N_IN): no grant, all in_ready=0.
// STRUCTURE
//   - Package stream_mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1 localparams.
//   - Sub-module mux_n_1_slice #(N_IN, SLICE_W): combinational N:1, SLICE_W-bit,
//     index select; instantiated W/SLICE_W times in a generate loop, all
//     sharing the grant index. Grant logic, rr_ptr and output register live in
//     stream_mux_sliced.
// TESTING  (N_IN=4, W=8, SLICE_W=2 unless noted)
//   - Reset: hold rst=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
//   - Fixed: mode=0, sel=2, in_data[2]=8'hA5, all valid, out_ready=1 -> next cycle
//     out_data=A5, out_src=2; in_ready=4'b0100 every cycle.
//   - Backpressure: out_ready=0 after first word -> out_data held, in_ready=0;
//     release -> next word accepted same edge, no gap, no duplicate.
//   - RR: mode=1, all valid, out_ready=1 -> out_src sequence 0,1,2,3,0 (wrap);
//     with only in_valid=4'b1010 -> 1,3,1,3.
//   - Slices: per-channel data 8'h1B,8'h2C,8'h3D,8'h4E -> every slice routes
//     correctly; repeat with W=12, SLICE_W=4, N_IN=3, sel=3 -> no grant.
//   - Mid-op reset: rst=0 while out_valid=1, out_ready=0 -> word dropped,
//     rr_ptr=0; first RR grant after reset is channel 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// ============================================================================
// Module : stream_mux_pkg
// Brief  : Shared constants for the sliced stream multiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

`default_nettype wire

// File: rtl/mux_n_1_slice.sv
// ============================================================================
// Module : mux_n_1_slice
// Brief  : Combinational N:1 multiplexer for one SLICE_W-bit slice, index select.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_n_1_slice #(
    parameter int N_IN    = 4,
    parameter int SLICE_W = 2
) (
    input  logic [N_IN*SLICE_W-1:0]  i_data,
    input  logic [$clog2(N_IN)-1:0]  i_sel,
    output logic [SLICE_W-1:0]       o_data
);
    localparam int SEL_W = $clog2(N_IN);

    // Out-of-range select yields zero rather than an X-prone part-select.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data = i_data[i*SLICE_W +: SLICE_W];
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/stream_mux_sliced.sv
// ============================================================================
// Module : stream_mux_sliced
// Brief  : Registered N:1 valid/ready stream mux, fixed or round-robin choice.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_sliced
    import stream_mux_pkg::*;
#(
    parameter int N_IN    = 4,
    parameter int W       = 8,
    parameter int SLICE_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [$clog2(N_IN)-1:0]  sel,
    input  logic [N_IN-1:0]          in_valid,
    input  logic [N_IN*W-1:0]        in_data,
    output logic [N_IN-1:0]          in_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(N_IN)-1:0]  out_src,
    input  logic                     out_ready
);
    localparam int SEL_W    = $clog2(N_IN);
    localparam int N_SLICES = W / SLICE_W;

    if (W % SLICE_W != 0) begin : g_width_check
        $error("stream_mux_sliced: W must be a multiple of SLICE_W");
    end

    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic [SEL_W-1:0]  r_out_src;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic              w_load_en;
    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_grant_idx;
    logic [SEL_W-1:0]  w_rr_next;
    logic [W-1:0]      w_mux_data;

    assign w_load_en = !r_out_valid || out_ready;

    // RR scan runs from the farthest offset down so the nearest valid channel
    // to rr_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (mode == MODE_RR) begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                idx = int'(r_rr_ptr) + k;
                if (idx >= N_IN) idx = idx - N_IN;
                if (in_valid[idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = SEL_W'(idx);
                end
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = sel;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = rst && w_load_en && w_grant_vld && (w_grant_idx == SEL_W'(i));
        end
    end

    assign w_rr_next = (w_grant_idx == SEL_W'(N_IN - 1)) ? '0 : w_grant_idx + 1'b1;

    // Each slice mux sees SLICE_W bits of every channel, all steered by one grant.
    for (genvar s = 0; s < N_SLICES; s++) begin : g_slice
        logic [N_IN*SLICE_W-1:0] w_slice_in;

        for (genvar c = 0; c < N_IN; c++) begin : g_chan
            assign w_slice_in[c*SLICE_W +: SLICE_W] = in_data[c*W + s*SLICE_W +: SLICE_W];
        end

        mux_n_1_slice #(
            .N_IN    (N_IN),
            .SLICE_W (SLICE_W)
        ) u_slice (
            .i_data (w_slice_in),
            .i_sel  (w_grant_idx),
            .o_data (w_mux_data[s*SLICE_W +: SLICE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            if (w_grant_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_src   <= w_grant_idx;
                if (mode == MODE_RR) begin
                    r_rr_ptr <= w_rr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
endmodule

`default_nettype wire

// File: tb/tb_stream_mux_sliced.sv
// ============================================================================
// Module : tb_stream_mux_sliced
// Brief  : Directed self-checking bench for stream_mux_sliced (two configurations).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux_sliced;
    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    // 4 x 8-bit, 2-bit slices
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    // 3 x 12-bit, 4-bit slices
    logic        mode_w;
    logic [1:0]  sel_w;
    logic [2:0]  in_valid_w;
    logic [35:0] in_data_w;
    logic [2:0]  in_ready_w;
    logic        out_valid_w;
    logic [11:0] out_data_w;
    logic [1:0]  out_src_w;
    logic        out_ready_w;

    always #5 clk = ~clk;

    stream_mux_sliced #(.N_IN(4), .W(8), .SLICE_W(2)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    stream_mux_sliced #(.N_IN(3), .W(12), .SLICE_W(4)) u_dut_w (
        .clk(clk), .rst(rst), .mode(mode_w), .sel(sel_w),
        .in_valid(in_valid_w), .in_data(in_data_w), .in_ready(in_ready_w),
        .out_valid(out_valid_w), .out_data(out_data_w), .out_src(out_src_w),
        .out_ready(out_ready_w)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, d1, d2, d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        mode_w = 1'b0; sel_w = 2'd0; in_valid_w = 3'b111; out_ready_w = 1'b1;
        in_data_w = 36'h789_456_123;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", out_src); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        checks++; if (in_ready_w !== 3'b000) begin errors++; $display("FAIL reset_in_ready_w got %b want 000", in_ready_w); end
        in_valid_w = 3'b000;
        rst = 1'b1;
    endtask

    task automatic test_fixed();
        logic [7:0] v [3];
        v[0] = 8'hA5; v[1] = 8'h5A; v[2] = 8'hC3;
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_data(8'h1B, 8'h2C, v[k], 8'h4E);
            #1;
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_in_ready[%0d] got %b want 0100", k, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== v[k] || out_src !== 2'd2) begin
                errors++; $display("FAIL fixed_word[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=2", k, out_valid, out_data, out_src, v[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_data(8'h1B, 8'h2C, 8'h77, 8'h4E);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0000", k, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_src !== 2'd2) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d want v=1 d=c3 s=2", k, out_valid, out_data, out_src);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_ready got %b want 0100", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin errors++; $display("FAIL bp_release_word got v=%b d=%h want v=1 d=77", out_valid, out_data); end
        set_data(8'h1B, 8'h2C, 8'h88, 8'h4E);
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h88) begin errors++; $display("FAIL bp_no_gap got v=%b d=%h want v=1 d=88", out_valid, out_data); end
        in_valid = 4'h0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_rr();
        int exp_a [5] = '{0, 1, 2, 3, 0};
        int exp_b [4] = '{1, 3, 1, 3};
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'hF;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (in_ready !== 4'(1 << exp_a[k])) begin errors++; $display("FAIL rr_ready[%0d] got %b want ch%0d", k, in_ready, exp_a[k]); end
            step();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'(exp_a[k]) || out_data !== 8'(8'h10 + exp_a[k])) begin
                errors++; $display("FAIL rr_all[%0d] got v=%b s=%0d d=%h want s=%0d", k, out_valid, out_src, out_data, exp_a[k]);
            end
        end
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_src !== 2'(exp_b[k]) || out_data !== 8'(8'h10 + exp_b[k])) begin
                errors++; $display("FAIL rr_sparse[%0d] got v=%b s=%0d d=%h want s=%0d", k, out_valid, out_src, out_data, exp_b[k]);
            end
        end
    endtask

    task automatic test_slices();
        logic [7:0] exp [4];
        exp[0] = 8'h1B; exp[1] = 8'h2C; exp[2] = 8'h3D; exp[3] = 8'h4E;
        mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        set_data(8'h1B, 8'h2C, 8'h3D, 8'h4E);
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            step();
            checks++; if (out_data !== exp[k] || out_src !== 2'(k)) begin
                errors++; $display("FAIL slice_ch%0d got d=%h s=%0d want d=%h", k, out_data, out_src, exp[k]);
            end
        end
    endtask

    task automatic test_wide();
        logic [11:0] exp [3];
        exp[0] = 12'h123; exp[1] = 12'h456; exp[2] = 12'h789;
        mode_w = 1'b0; in_valid_w = 3'b111; out_ready_w = 1'b1;
        in_data_w = 36'h789_456_123;
        for (int k = 0; k < 3; k++) begin
            sel_w = 2'(k);
            step();
            checks++; if (out_valid_w !== 1'b1 || out_data_w !== exp[k] || out_src_w !== 2'(k)) begin
                errors++; $display("FAIL wide_ch%0d got v=%b d=%h s=%0d want d=%h", k, out_valid_w, out_data_w, out_src_w, exp[k]);
            end
        end
        sel_w = 2'd3;
        #1;
        checks++; if (in_ready_w !== 3'b000) begin errors++; $display("FAIL wide_sel3_ready got %b want 000", in_ready_w); end
        step();
        checks++; if (out_valid_w !== 1'b0) begin errors++; $display("FAIL wide_sel3_valid got %b want 0", out_valid_w); end
    endtask

    task automatic test_midreset();
        mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        set_data(8'h61, 8'h62, 8'h63, 8'h64);
        step();
        out_ready = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h61) begin
            errors++; $display("FAIL mid_pre got v=%b s=%0d d=%h want v=1 s=0 d=61", out_valid, out_src, out_data);
        end
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0) begin
            errors++; $display("FAIL mid_reset got v=%b d=%h s=%0d want 0/00/0", out_valid, out_data, out_src);
        end
        rst = 1'b1; out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 8'h61) begin
            errors++; $display("FAIL mid_first_rr got v=%b s=%0d d=%h want v=1 s=0 d=61", out_valid, out_src, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_backpressure();
        test_rr();
        test_slices();
        test_wide();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
